// File: rtl/imem_fetch_unit.sv
// Instruction fetch responder: issues PC addresses to a multi-cycle instruction
// memory and buffers returned words in a 2-entry queue. FETCH_BYPASS_EN adds a same-cycle ack-to-decode path.
module imem_fetch_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] pc_addr,
    input  logic        flush,
    input  logic        dec_stall,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [11:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        insn_valid,
    output logic [31:0] insn,
    output logic [11:0] insn_pc,
    output logic [1:0]  fetch_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Handshake: imem_req rises with a new imem_addr and both hold until the
    // single-cycle imem_ack; a request is never withdrawn except by reset.
    state_t      state;
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] q_insn [2];
    logic [11:0] q_pc   [2];

    logic ack_wait;
    logic q_valid;
    logic bypass_hit;
    logic bypass_take;
    logic q_pop;
    logic q_push;
    logic room;
    logic capture;

    always_comb begin
        ack_wait = (state == ST_WAIT) && imem_ack;
        q_valid  = (count != 2'd0);
`ifdef FETCH_BYPASS_EN
        bypass_hit = ack_wait && !flush && (count == 2'd0);
`else
        bypass_hit = 1'b0;
`endif
        // A bypassed word that decode takes this cycle never occupies a slot.
        bypass_take = bypass_hit && !dec_stall;
        q_pop       = q_valid && !dec_stall && !flush;
        q_push      = ack_wait && !flush && !bypass_take;
        room        = ({1'b0, count} + {2'b00, q_push} + 3'd1) <= (3'd2 + {2'b00, q_pop});
        capture     = ((state == ST_IDLE) || ack_wait) && room && !flush;
        pc_stall    = reset || !(capture || flush);
    end

    assign insn_valid  = q_valid || bypass_hit;
    assign insn        = bypass_hit ? imem_rdata : q_insn[rd_ptr];
    assign insn_pc     = bypass_hit ? imem_addr  : q_pc[rd_ptr];
    assign fetch_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= 12'd0;
            count     <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                q_insn[i] <= 32'd0;
                q_pc[i]   <= 12'd0;
            end
        end else begin
            if (flush) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (q_push) begin
                    q_insn[wr_ptr] <= imem_rdata;
                    q_pc[wr_ptr]   <= imem_addr;
                    wr_ptr         <= ~wr_ptr;
                end
                if (q_pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + {1'b0, q_push} - {1'b0, q_pop};
            end

            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        imem_addr <= pc_addr;
                        imem_req  <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        if (capture) begin
                            imem_addr <= pc_addr;
                        end else begin
                            imem_req <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end else if (flush) begin
                        state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    // Wrong-path data: let the memory finish, then forget it.
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
